// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one external 8-bit adder among NREQ requesters.
// Optional build macro ADD_SHARE_SAT_EN: saturate res_data to 8'hFF on carry out.
module add_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] a_in,
    input  logic [8*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        adder_a,
    output logic [7:0]        adder_b,
    input  logic [7:0]        adder_result,
    output logic              res_valid,
    output logic [7:0]        res_data,
    output logic              res_carry,
    output logic [IDW-1:0]    res_id
);

    localparam int DATA_W = 8;
    localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef ADD_SHARE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W-1:0] sum,
                                                   input logic carry);
        return (SAT_EN && carry) ? {DATA_W{1'b1}} : sum;
    endfunction

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0] adda_p1_q, adda_p1_d;
    logic [DATA_W-1:0] addb_p1_q, addb_p1_d;
    logic              vld_p1_q, vld_p1_d;
    logic [IDW-1:0]    id_p1_q, id_p1_d;
    logic              vld_p2_q;
    logic [DATA_W-1:0] data_p2_q;
    logic              carry_p2_q;
    logic [IDW-1:0]    id_p2_q;

    logic [NREQ-1:0]   eligible;
    logic              grant_vld;
    logic [PW-1:0]     grant_idx;
    logic [PW:0]       scan_sum;
    logic [PW-1:0]     scan_idx;
    logic              carry_p1;

    // Stage 0: pick the first eligible requester at or after ptr, wrapping.
    always_comb begin
        eligible  = req & ~ack_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ)) begin
                scan_sum = scan_sum - (PW+1)'(NREQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        ack_d     = '0;
        adda_p1_d = adda_p1_q;
        addb_p1_d = addb_p1_q;
        vld_p1_d  = grant_vld;
        id_p1_d   = id_p1_q;
        if (grant_vld) begin
            ptr_d            = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            ack_d[grant_idx] = 1'b1;
            id_p1_d          = IDW'(grant_idx);
            for (int k = 0; k < NREQ; k++) begin
                if (grant_idx == PW'(k)) begin
                    adda_p1_d = a_in[k*DATA_W +: DATA_W];
                    addb_p1_d = b_in[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Stage 1: operand registers feed the shared adder; carry recovered by compare.
    assign carry_p1 = (adder_result < adda_p1_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q      <= '0;
            ack_q      <= '0;
            adda_p1_q  <= '0;
            addb_p1_q  <= '0;
            vld_p1_q   <= 1'b0;
            id_p1_q    <= '0;
            vld_p2_q   <= 1'b0;
            data_p2_q  <= '0;
            carry_p2_q <= 1'b0;
            id_p2_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            adda_p1_q  <= adda_p1_d;
            addb_p1_q  <= addb_p1_d;
            vld_p1_q   <= vld_p1_d;
            id_p1_q    <= id_p1_d;
            // Stage 2: registered result
            vld_p2_q   <= vld_p1_q;
            id_p2_q    <= id_p1_q;
            carry_p2_q <= carry_p1;
            data_p2_q  <= sat_sum(adder_result, carry_p1);
        end
    end

    assign ack       = ack_q;
    assign adder_a   = adda_p1_q;
    assign adder_b   = addb_p1_q;
    assign res_valid = vld_p2_q;
    assign res_data  = data_p2_q;
    assign res_carry = carry_p2_q;
    assign res_id    = id_p2_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: reference arbiter model pushes expected results, monitor pops.
module tb_add_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] a_in;
    logic [8*NREQ-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic [7:0]        adder_a;
    logic [7:0]        adder_b;
    logic [7:0]        adder_result;
    logic              res_valid;
    logic [7:0]        res_data;
    logic              res_carry;
    logic [IDW-1:0]    res_id;

    add_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clock(clock), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .adder_a(adder_a), .adder_b(adder_b), .adder_result(adder_result),
        .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry), .res_id(res_id)
    );

    // Stand-in for the shared adder megacell.
    assign adder_result = adder_a + adder_b;

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        int         id;
        int         due;
    } exp_t;

    exp_t            sbq[$];
    exp_t            item;
    exp_t            got;
    int              cyc = 0;
    int              n_cmp = 0;
    int              n_fail = 0;
    int              mptr = 0;
    int              w;
    int              j;
    logic [NREQ-1:0] mack = '0;
    logic [NREQ-1:0] elig;
    logic [7:0]      exp_a = '0;
    logic [7:0]      exp_b = '0;
    logic [8:0]      s9;
    bit              after_rst = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: round-robin over (req & ~last ack), evaluated on each rising edge.
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            mptr = 0;
            mack = '0;
            exp_a = '0;
            exp_b = '0;
            sbq.delete();
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            elig = req & ~mack;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                j = (mptr + k) % NREQ;
                if (w < 0 && elig[j]) w = j;
            end
            mack = '0;
            if (w >= 0) begin
                mack[w] = 1'b1;
                mptr = (w + 1) % NREQ;
                exp_a = a_in[8*w +: 8];
                exp_b = b_in[8*w +: 8];
                s9 = {1'b0, exp_a} + {1'b0, exp_b};
                item.carry = s9[8];
`ifdef ADD_SHARE_SAT_EN
                item.data = s9[8] ? 8'hFF : s9[7:0];
`else
                item.data = s9[7:0];
`endif
                item.id = w;
                item.due = cyc + 1;
                sbq.push_back(item);
            end
        end
    end

    // Monitor: compares DUT outputs on the falling edge.
    always @(negedge clock) begin
        if (cyc > 0) begin
            check("ack", ack, mack);
            check("adder_a", adder_a, exp_a);
            check("adder_b", adder_b, exp_b);
            if (after_rst) begin
                check("rst_res_valid", res_valid, 0);
                check("rst_res_data", res_data, 0);
                check("rst_res_carry", res_carry, 0);
                check("rst_res_id", res_id, 0);
            end else if (res_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_res_valid", 1, 0);
                end else begin
                    got = sbq.pop_front();
                    check("res_due_cycle", cyc, got.due);
                    check("res_id", res_id, got.id);
                    check("res_data", res_data, got.data);
                    check("res_carry", res_carry, got.carry);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                got = sbq.pop_front();
                check("missing_res_valid", 0, 1);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // single request on requester 2
        a_in[23:16] = 8'h12;
        b_in[23:16] = 8'h34;
        req = 4'b0100;
        step();
        req = '0;
        repeat (3) step();

        // all four held from a fresh reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_in[8*i +: 8] = 8'($urandom);
            b_in[8*i +: 8] = 8'($urandom);
        end
        req = '1;
        repeat (12) step();
        req = '0;
        repeat (3) step();

        // overflow on requester 0
        a_in[7:0] = 8'hF0;
        b_in[7:0] = 8'h20;
        req = 4'b0001;
        step();
        req = '0;
        repeat (3) step();

        // requester 1 held for 6 cycles
        a_in[15:8] = 8'h7F;
        b_in[15:8] = 8'h81;
        req = 4'b0010;
        repeat (6) step();
        req = '0;
        repeat (3) step();

        // reset while an operation is in flight
        a_in[31:24] = 8'hA5;
        b_in[31:24] = 8'h5A;
        req = 4'b1000;
        step();
        req = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        req = 4'b1010;
        step();
        req = '0;
        repeat (3) step();

        // randomized traffic obeying the operand-stability contract
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        a_in[8*i +: 8] = 8'($urandom);
                        b_in[8*i +: 8] = 8'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(0, 9) < 4) begin
                    a_in[8*i +: 8] = 8'($urandom);
                    b_in[8*i +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end
            end
            step();
        end
        reset = 1'b0;
        req = '0;
        repeat (6) step();
        check("drained_queue", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
